gnrl_bus_mux: RTL and testbench

- Shared-bus request mux that sits directly downstream of the 3-way round-robin arbiter (gnrl_arb).
- Consumes the arbiter's one-hot grant vector and forwards one transaction from the granted master to a single shared slave over a valid/ready handshake.
- Returns the slave response to the owning master and pulses that master's end-access bit back to the arbiter.
- One transaction outstanding at a time.

---
 rtl/gnrl_bus_mux.sv | 157 +++++++++++++++
 tb/tb_gnrl_bus_mux.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnrl_bus_mux.sv
// Shared-bus request mux behind the 3-way round-robin arbiter: forwards one granted transaction to the slave.
// Optional response watchdog enabled by defining GNRL_BUS_MUX_TIMEOUT_EN.
module gnrl_bus_mux #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              i_gnt_vec,
    input  logic [2:0]              i_m_req_vld,
    input  logic [3*ADDR_WIDTH-1:0] i_m_req_addr,
    input  logic [2:0]              i_m_req_wen,
    input  logic [3*DATA_WIDTH-1:0] i_m_req_wdata,
    output logic [2:0]              o_m_req_rdy,
    output logic [2:0]              o_m_rsp_vld,
    output logic [DATA_WIDTH-1:0]   o_m_rsp_rdata,
    output logic [2:0]              o_end_access_vec,
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
    output logic                    o_m_rsp_err,
`endif
    output logic                    o_s_req_vld,
    input  logic                    i_s_req_rdy,
    output logic [ADDR_WIDTH-1:0]   o_s_req_addr,
    output logic                    o_s_req_wen,
    output logic [DATA_WIDTH-1:0]   o_s_req_wdata,
    input  logic                    i_s_rsp_vld,
    input  logic [DATA_WIDTH-1:0]   i_s_rsp_rdata,
    output logic                    o_s_rsp_rdy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_REQ  = 3'b010,
        ST_RSP  = 3'b100
    } state_e;

    state_e                  state_q;
    logic [1:0]              owner_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wen_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              rsp_vld_q;
    logic [2:0]              end_access_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic [2:0]              sel;
    logic                    gnt_onehot;
    logic                    accept;
    logic [1:0]              owner_d;
    logic [2:0]              owner_vec;

    assign sel        = i_gnt_vec & i_m_req_vld;
    assign gnt_onehot = (i_gnt_vec != 3'b000) && ((i_gnt_vec & (i_gnt_vec - 3'd1)) == 3'b000);
    // The end-access cycle is already IDLE, but the arbiter must see it before a new accept.
    assign accept     = !rst && (state_q == ST_IDLE) && gnt_onehot && (sel != 3'b000)
                        && (end_access_q == 3'b000);
    assign owner_vec  = 3'b001 << owner_q;

    always_comb begin
        owner_d = 2'd0;
        if (sel[1]) begin
            owner_d = 2'd1;
        end else if (sel[2]) begin
            owner_d = 2'd2;
        end
    end

`ifdef GNRL_BUS_MUX_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    assign o_m_rsp_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= 2'd0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            rsp_vld_q    <= 3'b000;
            end_access_q <= 3'b000;
            rdata_q      <= '0;
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            rsp_vld_q    <= 3'b000;
            end_access_q <= 3'b000;
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        owner_q <= owner_d;
                        addr_q  <= i_m_req_addr[int'(owner_d)*ADDR_WIDTH +: ADDR_WIDTH];
                        wen_q   <= i_m_req_wen[owner_d];
                        wdata_q <= i_m_req_wdata[int'(owner_d)*DATA_WIDTH +: DATA_WIDTH];
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_s_req_rdy) begin
                        state_q <= ST_RSP;
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                ST_RSP: begin
                    // A real response in the expiry cycle takes priority over the timeout.
                    if (i_s_rsp_vld) begin
                        rsp_vld_q    <= owner_vec;
                        end_access_q <= owner_vec;
                        rdata_q      <= i_s_rsp_rdata;
                        state_q      <= ST_IDLE;
                    end
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        rsp_vld_q    <= owner_vec;
                        end_access_q <= owner_vec;
                        rdata_q      <= '0;
                        err_q        <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_m_req_rdy      = accept ? sel : 3'b000;
    assign o_m_rsp_vld      = rsp_vld_q;
    assign o_m_rsp_rdata    = rdata_q;
    assign o_end_access_vec = end_access_q;
    assign o_s_req_vld      = (state_q == ST_REQ);
    assign o_s_req_addr     = addr_q;
    assign o_s_req_wen      = wen_q;
    assign o_s_req_wdata    = wdata_q;
    assign o_s_rsp_rdy      = (state_q == ST_RSP);

endmodule

// File: tb/tb_gnrl_bus_mux.sv
// Directed, table-driven bench for gnrl_bus_mux; timeout scenarios run when GNRL_BUS_MUX_TIMEOUT_EN is defined.
module tb_gnrl_bus_mux;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    i_gnt_vec;
    logic [2:0]    i_m_req_vld;
    logic [3*AW-1:0] i_m_req_addr;
    logic [2:0]    i_m_req_wen;
    logic [3*DW-1:0] i_m_req_wdata;
    logic [2:0]    o_m_req_rdy;
    logic [2:0]    o_m_rsp_vld;
    logic [DW-1:0] o_m_rsp_rdata;
    logic [2:0]    o_end_access_vec;
    logic          o_s_req_vld;
    logic          i_s_req_rdy;
    logic [AW-1:0] o_s_req_addr;
    logic          o_s_req_wen;
    logic [DW-1:0] o_s_req_wdata;
    logic          i_s_rsp_vld;
    logic [DW-1:0] i_s_rsp_rdata;
    logic          o_s_rsp_rdy;
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
    logic          o_m_rsp_err;
`endif

    always #5 clk = ~clk;

    gnrl_bus_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_gnt_vec(i_gnt_vec), .i_m_req_vld(i_m_req_vld), .i_m_req_addr(i_m_req_addr),
        .i_m_req_wen(i_m_req_wen), .i_m_req_wdata(i_m_req_wdata), .o_m_req_rdy(o_m_req_rdy),
        .o_m_rsp_vld(o_m_rsp_vld), .o_m_rsp_rdata(o_m_rsp_rdata), .o_end_access_vec(o_end_access_vec),
`ifdef GNRL_BUS_MUX_TIMEOUT_EN
        .o_m_rsp_err(o_m_rsp_err),
`endif
        .o_s_req_vld(o_s_req_vld), .i_s_req_rdy(i_s_req_rdy), .o_s_req_addr(o_s_req_addr),
        .o_s_req_wen(o_s_req_wen), .o_s_req_wdata(o_s_req_wdata), .i_s_rsp_vld(i_s_rsp_vld),
        .i_s_rsp_rdata(i_s_rsp_rdata), .o_s_rsp_rdy(o_s_rsp_rdy)
    );

    typedef struct {
        logic [2:0]  gnt;
        logic [2:0]  vld;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          bp;
        logic [2:0]  exp_rdy;
    } vec_t;

    vec_t vt[7];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner slot gets the real fields; the other slots get distinct decoys.
    task automatic drive_masters(input int idx, input logic [31:0] addr, input logic wen,
                                 input logic [31:0] wdata);
        for (int j = 0; j < 3; j++) begin
            i_m_req_addr[j*AW +: AW]  = (j == idx) ? addr  : (addr  ^ 32'hF000_0000 ^ 32'(j));
            i_m_req_wdata[j*DW +: DW] = (j == idx) ? wdata : (wdata ^ 32'h0F00_0000 ^ 32'(j));
            i_m_req_wen[j]            = (j == idx) ? wen : ~wen;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int idx;
        idx = v.exp_rdy[1] ? 1 : (v.exp_rdy[2] ? 2 : 0);
        i_gnt_vec   = v.gnt;
        i_m_req_vld = v.vld;
        drive_masters(idx, v.addr, v.wen, v.wdata);
        #1 chk("accept_rdy", o_m_req_rdy, v.exp_rdy);
        if (v.exp_rdy == 3'b000) begin
            tick();
            chk("idle_hold_s_req_vld", o_s_req_vld, 0);
            chk("idle_hold_rdy", o_m_req_rdy, 0);
            i_m_req_vld = 3'b000;
            i_gnt_vec   = 3'b000;
            return;
        end
        tick();
        i_m_req_vld   = 3'b000;
        i_m_req_addr  = ~i_m_req_addr;
        i_m_req_wdata = ~i_m_req_wdata;
        i_m_req_wen   = ~i_m_req_wen;
        i_s_rsp_vld   = 1'b1;
        i_s_rsp_rdata = 32'hBAD0_BAD0;
        for (int c = 0; c < v.bp; c++) begin
            #1;
            chk("bp_s_req_vld", o_s_req_vld, 1);
            chk("bp_addr", o_s_req_addr, v.addr);
            chk("bp_wdata", o_s_req_wdata, v.wdata);
            chk("bp_wen", o_s_req_wen, v.wen);
            chk("bp_rsp_rdy", o_s_rsp_rdy, 0);
            tick();
        end
        i_s_req_rdy = 1'b1;
        #1;
        chk("req_vld", o_s_req_vld, 1);
        chk("req_addr", o_s_req_addr, v.addr);
        chk("req_wen", o_s_req_wen, v.wen);
        chk("req_wdata", o_s_req_wdata, v.wdata);
        tick();
        i_s_req_rdy = 1'b0;
        i_s_rsp_vld = 1'b0;
        #1;
        chk("rsp_rdy", o_s_rsp_rdy, 1);
        chk("rsp_phase_s_req_vld", o_s_req_vld, 0);
        chk("rsp_phase_m_rsp_vld", o_m_rsp_vld, 0);
        i_s_rsp_vld   = 1'b1;
        i_s_rsp_rdata = v.rdata;
        tick();
        i_s_rsp_vld = 1'b0;
        chk("m_rsp_vld", o_m_rsp_vld, v.exp_rdy);
        chk("m_rsp_rdata", o_m_rsp_rdata, v.rdata);
        chk("end_access", o_end_access_vec, v.exp_rdy);
        tick();
        chk("m_rsp_vld_drop", o_m_rsp_vld, 0);
        chk("end_access_drop", o_end_access_vec, 0);
        chk("rdata_hold", o_m_rsp_rdata, v.rdata);
        i_gnt_vec = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'b010, 3'b111, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 3'b010};
        vt[1] = '{3'b100, 3'b100, 32'h0000_0200, 1'b1, 32'h0000_0055, 32'h0000_0001, 5, 3'b100};
        vt[2] = '{3'b011, 3'b111, 32'h0000_0300, 1'b0, 32'h0000_0000, 32'h0, 0, 3'b000};
        vt[3] = '{3'b000, 3'b111, 32'h0000_0300, 1'b0, 32'h0000_0000, 32'h0, 0, 3'b000};
        vt[4] = '{3'b001, 3'b001, 32'h0000_0ABC, 1'b1, 32'h1234_5678, 32'hCAFE_F00D, 2, 3'b001};
        vt[5] = '{3'b001, 3'b110, 32'h0000_0500, 1'b0, 32'h0000_0000, 32'h0, 0, 3'b000};
        vt[6] = '{3'b111, 3'b111, 32'h0000_0600, 1'b0, 32'h0000_0000, 32'h0, 0, 3'b000};

        rst           = 1'b1;
        i_gnt_vec     = 3'b001;
        i_m_req_vld   = 3'b111;
        i_s_req_rdy   = 1'b0;
        i_s_rsp_vld   = 1'b0;
        i_s_rsp_rdata = '0;
        drive_masters(0, 32'h0000_0A00, 1'b1, 32'h0000_00AA);

        // Reset held for two cycles with a valid grant/request present.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_rdy", o_m_req_rdy, 0);
            chk("rst_m_rsp_vld", o_m_rsp_vld, 0);
            chk("rst_end_access", o_end_access_vec, 0);
            chk("rst_s_req_vld", o_s_req_vld, 0);
            chk("rst_rdata", o_m_rsp_rdata, 0);
            chk("rst_s_req_addr", o_s_req_addr, 0);
            chk("rst_s_req_wen", o_s_req_wen, 0);
            chk("rst_s_req_wdata", o_s_req_wdata, 0);
            chk("rst_s_rsp_rdy", o_s_rsp_rdy, 0);
        end
        rst = 1'b0;
        #1 chk("post_rst_rdy", o_m_req_rdy, 3'b001);
        tick();
        chk("post_rst_s_req_vld", o_s_req_vld, 1);
        chk("post_rst_addr", o_s_req_addr, 32'h0000_0A00);

        // Reset during an in-flight request drops it without a response.
        rst         = 1'b1;
        i_m_req_vld = 3'b000;
        i_gnt_vec   = 3'b000;
        tick();
        rst = 1'b0;
        chk("drop_s_req_vld", o_s_req_vld, 0);
        chk("drop_s_req_addr", o_s_req_addr, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("drop_no_rsp", {o_m_rsp_vld, o_end_access_vec, o_s_rsp_rdy}, 0);
        end

        for (int k = 0; k < 7; k++) begin
            run_vec(vt[k]);
            tick();
        end

        // Grant moves to master2 while master0's transaction is in RSP.
        i_gnt_vec   = 3'b001;
        i_m_req_vld = 3'b001;
        drive_masters(0, 32'h0000_0300, 1'b0, 32'h0);
        #1 chk("gc_accept0", o_m_req_rdy, 3'b001);
        tick();
        i_m_req_vld = 3'b000;
        i_s_req_rdy = 1'b1;
        tick();
        i_s_req_rdy = 1'b0;
        i_gnt_vec   = 3'b100;
        i_m_req_vld = 3'b100;
        drive_masters(2, 32'h0000_0400, 1'b1, 32'h0000_0077);
        #1 chk("gc_rdy_in_rsp", o_m_req_rdy, 0);
        i_s_rsp_vld   = 1'b1;
        i_s_rsp_rdata = 32'h1111_2222;
        tick();
        i_s_rsp_vld = 1'b0;
        chk("gc_rsp_vld_m0", o_m_rsp_vld, 3'b001);
        chk("gc_end_m0", o_end_access_vec, 3'b001);
        chk("gc_rdata", o_m_rsp_rdata, 32'h1111_2222);
        chk("gc_rdy_end_cycle", o_m_req_rdy, 0);
        tick();
        chk("gc_accept2", o_m_req_rdy, 3'b100);
        tick();
        i_m_req_vld = 3'b000;
        chk("gc_addr2", o_s_req_addr, 32'h0000_0400);
        chk("gc_wdata2", o_s_req_wdata, 32'h0000_0077);
        i_s_req_rdy = 1'b1;
        tick();
        i_s_req_rdy   = 1'b0;
        i_s_rsp_vld   = 1'b1;
        i_s_rsp_rdata = 32'h0000_0033;
        tick();
        i_s_rsp_vld = 1'b0;
        chk("gc_rsp_vld_m2", o_m_rsp_vld, 3'b100);
        chk("gc_end_m2", o_end_access_vec, 3'b100);
        i_gnt_vec = 3'b000;
        tick();

`ifdef GNRL_BUS_MUX_TIMEOUT_EN
        // No slave response: expiry after 8 RSP cycles.
        i_gnt_vec   = 3'b010;
        i_m_req_vld = 3'b010;
        drive_masters(1, 32'h0000_0700, 1'b0, 32'h0);
        #1 chk("to_accept", o_m_req_rdy, 3'b010);
        tick();
        i_m_req_vld = 3'b000;
        i_s_req_rdy = 1'b1;
        tick();
        i_s_req_rdy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("to_wait", {o_m_rsp_vld, o_m_rsp_err}, 0);
            tick();
        end
        chk("to_err", o_m_rsp_err, 1);
        chk("to_rsp_vld", o_m_rsp_vld, 3'b010);
        chk("to_end", o_end_access_vec, 3'b010);
        chk("to_rdata", o_m_rsp_rdata, 0);
        tick();
        chk("to_err_drop", o_m_rsp_err, 0);
        chk("to_idle", o_s_rsp_rdy, 0);

        // Response arriving in the expiry cycle wins.
        i_m_req_vld = 3'b010;
        #1 chk("to2_accept", o_m_req_rdy, 3'b010);
        tick();
        i_m_req_vld = 3'b000;
        i_s_req_rdy = 1'b1;
        tick();
        i_s_req_rdy = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        i_s_rsp_vld   = 1'b1;
        i_s_rsp_rdata = 32'h0000_0077;
        tick();
        i_s_rsp_vld = 1'b0;
        chk("to2_err", o_m_rsp_err, 0);
        chk("to2_rsp_vld", o_m_rsp_vld, 3'b010);
        chk("to2_rdata", o_m_rsp_rdata, 32'h0000_0077);
        i_gnt_vec = 3'b000;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
